scratchpad_sram: RTL

SCRATCHPAD_SRAM -- requirements
Module: scratchpad_sram

---
 rtl/scratchpad_sram_if.sv | 31 +++
 rtl/scratchpad_sram.sv | 113 +++++++++++
 2 files changed

// File: rtl/scratchpad_sram_if.sv
// Port bundle for scratchpad_sram: byte-enabled write port, read port and clear control.
// The master drives requests; the slave returns read data, collision flag and clear status.
interface scratchpad_sram_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 12
);
   localparam int BE_W = DATA_W / 8;

   logic              ena;
   logic [BE_W-1:0]   wea;
   logic [ADDR_W-1:0] addra;
   logic [DATA_W-1:0] dina;
   logic              enb;
   logic [ADDR_W-1:0] addrb;
   logic [DATA_W-1:0] doutb;
   logic              doutb_vld;
   logic              rd_coll;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;

   modport master (
      output ena, wea, addra, dina, enb, addrb, clr_req,
      input  doutb, doutb_vld, rd_coll, clr_busy, clr_done
   );

   modport slave (
      input  ena, wea, addra, dina, enb, addrb, clr_req,
      output doutb, doutb_vld, rd_coll, clr_busy, clr_done
   );
endinterface

// File: rtl/scratchpad_sram.sv
// Simple dual-port scratchpad with byte writes, read-first collisions and a zero-fill engine.
// Read latency RD_LAT cycles at full throughput; no backpressure, port accesses are dropped while a clear runs.
module scratchpad_sram #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   scratchpad_sram_if.slave bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("scratchpad_sram: RD_LAT=%0d outside legal range 1..4", RD_LAT);
   end
   if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("scratchpad_sram: DATA_W=%0d is not a multiple of 8", DATA_W);
   end

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

   clr_state_t        state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              clr_busy_q;
   logic              clr_done_q;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              rd_acc;
   logic              wr_acc;

   // Stage 0 samples the array; stage RD_LAT-1 is the output register.
   logic [DATA_W-1:0] stg_dat [RD_LAT];
   logic [RD_LAT-1:0] stg_vld;
   logic [RD_LAT-1:0] stg_col;

   assign rd_acc = bus.enb && !clr_busy_q;
   assign wr_acc = bus.ena && (|bus.wea) && !clr_busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         clr_cnt    <= '0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               clr_done_q <= 1'b0;
               if (bus.clr_req) begin
                  state      <= CLEAR;
                  clr_cnt    <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               // Stop on the last word instead of letting the counter wrap.
               if (clr_cnt == '1) begin
                  state      <= DONE;
                  clr_busy_q <= 1'b0;
                  clr_done_q <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               clr_done_q <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               clr_busy_q <= 1'b0;
               clr_done_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && clr_busy_q) begin
         mem[clr_cnt] <= '0;
      end else if (!rst && wr_acc) begin
         for (int i = 0; i < BE_W; i++) begin
            if (bus.wea[i]) mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_vld <= '0;
         stg_col <= '0;
         for (int i = 0; i < RD_LAT; i++) stg_dat[i] <= '0;
      end else begin
         stg_vld[0] <= rd_acc;
         stg_col[0] <= rd_acc && wr_acc && (bus.addra == bus.addrb);
         if (rd_acc) stg_dat[0] <= mem[bus.addrb];
         // Stages only load on valid data, so the output register holds between results.
         for (int i = 1; i < RD_LAT; i++) begin
            stg_vld[i] <= stg_vld[i-1];
            stg_col[i] <= stg_col[i-1];
            if (stg_vld[i-1]) stg_dat[i] <= stg_dat[i-1];
         end
      end
   end

   assign bus.doutb     = stg_dat[RD_LAT-1];
   assign bus.doutb_vld = stg_vld[RD_LAT-1];
   assign bus.rd_coll   = stg_col[RD_LAT-1];
   assign bus.clr_busy  = clr_busy_q;
   assign bus.clr_done  = clr_done_q;
endmodule
